// File: rtl/pipe_pkg.sv
// Shared types and helpers for the inter-stage valid/ready buffers.
// Holds the perf counter type, the modulo pointer increment, and the
// default payload width and depth for each pipeline stage bus.
package pipe_pkg;

    typedef logic [31:0] perf_cnt_t;

    // Default bus geometry per stage boundary
    localparam int FD_WIDTH = 64;
    localparam int FD_DEPTH = 2;
    localparam int DX_WIDTH = 128;
    localparam int DX_DEPTH = 2;
    localparam int XM_WIDTH = 96;
    localparam int XM_DEPTH = 2;
    localparam int MW_WIDTH = 64;
    localparam int MW_DEPTH = 1;

    // Advance a ring pointer, wrapping DEPTH-1 back to 0 (DEPTH need not be 2^n)
    function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
        return (ptr + 1 >= depth) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/pipe_stage_perf.sv
// Performance counters for one pipeline buffer output port.
// Only built when PIPE_STAGE_PERF_EN is defined; otherwise this file
// contributes no module and the buffer ties its perf outputs to zero.
// Counters wrap at 2^32, are cleared by rst and ignore flush.
`ifdef PIPE_STAGE_PERF_EN
module pipe_stage_perf
    import pipe_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      m_valid,
    input  logic      m_ready,
    output perf_cnt_t perf_stall,
    output perf_cnt_t perf_bubble,
    output perf_cnt_t perf_xfer
);

    perf_cnt_t r_stall;
    perf_cnt_t r_bubble;
    perf_cnt_t r_xfer;

    // Classify every cycle of the output handshake and count it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_stall  <= '0;
            r_bubble <= '0;
            r_xfer   <= '0;
        end else begin
            if (m_valid && !m_ready) r_stall  <= r_stall + 32'd1;
            if (!m_valid && m_ready) r_bubble <= r_bubble + 32'd1;
            if (m_valid && m_ready)  r_xfer   <= r_xfer + 32'd1;
        end
    end

    assign perf_stall  = r_stall;
    assign perf_bubble = r_bubble;
    assign perf_xfer   = r_xfer;

endmodule
`endif

// File: rtl/pipe_stage_buf.sv
// Valid/ready FIFO buffer between two pipeline stages.
// DEPTH entries of WIDTH bits, synchronous flush for wrong-path squash,
// occupancy status. Optional perf counters under PIPE_STAGE_PERF_EN.
// READY_COMB=1 lets a full buffer accept while the head is being popped.
module pipe_stage_buf
    import pipe_pkg::*;
#(
    parameter int WIDTH      = 32,
    parameter int DEPTH      = 2,
    parameter int READY_COMB = 0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       s_valid,
    output logic                       s_ready,
    input  logic [WIDTH-1:0]           s_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [WIDTH-1:0]           m_data,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       full,
    output logic                       empty,
    output perf_cnt_t                  perf_stall,
    output perf_cnt_t                  perf_bubble,
    output perf_cnt_t                  perf_xfer
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    logic w_full;
    logic w_empty;
    logic w_push;
    logic w_pop;

    assign w_full  = (r_count == FULL_CNT);
    assign w_empty = (r_count == '0);

    // The combinational variant frees the slot being popped this cycle
    if (READY_COMB != 0) begin : g_ready_comb
        assign s_ready = ~w_full | m_ready;
    end else begin : g_ready_reg
        assign s_ready = ~w_full;
    end

    assign w_push  = s_valid & s_ready;
    assign w_pop   = ~w_empty & m_ready;

    assign m_valid = ~w_empty;
    assign m_data  = r_mem[r_rd_ptr];
    assign count   = r_count;
    assign full    = w_full;
    assign empty   = w_empty;

    // Pointer and occupancy update; flush and rst squash both beats of the cycle
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= PTR_W'(ptr_inc(32'(r_wr_ptr), DEPTH));
            if (w_pop)  r_rd_ptr <= PTR_W'(ptr_inc(32'(r_rd_ptr), DEPTH));
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Payload storage; stale slots after a flush are never observed
    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr_ptr] <= s_data;
    end

`ifdef PIPE_STAGE_PERF_EN
    pipe_stage_perf u_perf (
        .clk         (clk),
        .rst         (rst),
        .m_valid     (m_valid),
        .m_ready     (m_ready),
        .perf_stall  (perf_stall),
        .perf_bubble (perf_bubble),
        .perf_xfer   (perf_xfer)
    );
`else
    assign perf_stall  = '0;
    assign perf_bubble = '0;
    assign perf_xfer   = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: three instances
//   A: DEPTH=2 READY_COMB=0   B: DEPTH=3 READY_COMB=1   C: DEPTH=3 READY_COMB=0
module tb_pipe_stage_buf;

`ifdef PIPE_STAGE_PERF_EN
    localparam int PE = 1;
`else
    localparam int PE = 0;
`endif

    logic clk;
    logic rst;

    logic        fl_a, sv_a, sr_a, mv_a, mr_a, full_a, empty_a;
    logic [31:0] sd_a, md_a, ps_a, pb_a, px_a;
    logic [1:0]  cnt_a;
    logic        fl_b, sv_b, sr_b, mv_b, mr_b, full_b, empty_b;
    logic [31:0] sd_b, md_b, ps_b, pb_b, px_b;
    logic [1:0]  cnt_b;
    logic        fl_c, sv_c, sr_c, mv_c, mr_c, full_c, empty_c;
    logic [31:0] sd_c, md_c, ps_c, pb_c, px_c;
    logic [1:0]  cnt_c;

    int checks = 0;
    int errors = 0;

    pipe_stage_buf #(.WIDTH(32), .DEPTH(2), .READY_COMB(0)) u_a (
        .clk(clk), .rst(rst), .flush(fl_a), .s_valid(sv_a), .s_ready(sr_a), .s_data(sd_a),
        .m_valid(mv_a), .m_ready(mr_a), .m_data(md_a), .count(cnt_a), .full(full_a),
        .empty(empty_a), .perf_stall(ps_a), .perf_bubble(pb_a), .perf_xfer(px_a));

    pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .READY_COMB(1)) u_b (
        .clk(clk), .rst(rst), .flush(fl_b), .s_valid(sv_b), .s_ready(sr_b), .s_data(sd_b),
        .m_valid(mv_b), .m_ready(mr_b), .m_data(md_b), .count(cnt_b), .full(full_b),
        .empty(empty_b), .perf_stall(ps_b), .perf_bubble(pb_b), .perf_xfer(px_b));

    pipe_stage_buf #(.WIDTH(32), .DEPTH(3), .READY_COMB(0)) u_c (
        .clk(clk), .rst(rst), .flush(fl_c), .s_valid(sv_c), .s_ready(sr_c), .s_data(sd_c),
        .m_valid(mv_c), .m_ready(mr_c), .m_data(md_c), .count(cnt_c), .full(full_c),
        .empty(empty_c), .perf_stall(ps_c), .perf_bubble(pb_c), .perf_xfer(px_c));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Upstream protocol: an unaccepted beat must be held with stable data
    property p_hold_a;
        @(posedge clk) disable iff (rst) (sv_a && !sr_a) |=> (sv_a && $stable(sd_a));
    endproperty
    assert property (p_hold_a);

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        fl_a = 0; sv_a = 0; sd_a = 0; mr_a = 0;
        fl_b = 0; sv_b = 0; sd_b = 0; mr_b = 0;
        fl_c = 0; sv_c = 0; sd_c = 0; mr_c = 0;
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("rst_cnt",   32'(cnt_a),   0);
        chk("rst_empty", 32'(empty_a), 1);
        chk("rst_full",  32'(full_a),  0);
        chk("rst_mv",    32'(mv_a),    0);
        chk("rst_sr",    32'(sr_a),    1);
        chk("rst_pstall", ps_b, 0);

        // T1 fill/drain on DEPTH=2
        sv_a = 1; sd_a = 32'hA; mr_a = 0;
        tick();
        chk("t1_cnt1", 32'(cnt_a), 1);
        chk("t1_md1",  md_a, 32'hA);
        sd_a = 32'hB;
        tick();
        sv_a = 0;
        #1;
        chk("t1_cnt2", 32'(cnt_a), 2);
        chk("t1_full", 32'(full_a), 1);
        chk("t1_sr",   32'(sr_a), 0);
        chk("t1_head", md_a, 32'hA);
        mr_a = 1;
        tick();
        chk("t1_pop1", md_a, 32'hB);
        chk("t1_cnt_after_pop", 32'(cnt_a), 1);
        tick();
        chk("t1_empty", 32'(empty_a), 1);
        chk("t1_mv",    32'(mv_a), 0);
        mr_a = 0;

        // T2 streaming throughput on DEPTH=2
        sv_a = 1; mr_a = 1;
        for (int i = 0; i < 100; i++) begin
            sd_a = 32'(i);
            #1;
            if (i > 0) begin
                chk("t2_data", md_a, 32'(i - 1));
                chk("t2_cnt",  32'(cnt_a), 1);
                chk("t2_sr",   32'(sr_a), 1);
            end
            tick();
        end
        sv_a = 0;
        #1;
        chk("t2_last", md_a, 32'd99);
        tick();
        chk("t2_empty", 32'(empty_a), 1);
        mr_a = 0;

        // T4 flush with push and pop in the same cycle (DEPTH=3, READY_COMB=1)
        sv_b = 1; sd_b = 32'h11; mr_b = 0;
        tick();
        sd_b = 32'h22;
        tick();
        sd_b = 32'h33; mr_b = 1; fl_b = 1;
        #1;
        chk("t4_cnt_pre", 32'(cnt_b), 2);
        chk("t4_sr",      32'(sr_b), 1);
        tick();
        fl_b = 0; sv_b = 0; mr_b = 0;
        #1;
        chk("t4_cnt", 32'(cnt_b), 0);
        chk("t4_mv",  32'(mv_b), 0);
        sv_b = 1; sd_b = 32'h55;
        tick();
        sv_b = 0;
        #1;
        chk("t4_data", md_b, 32'h55);
        chk("t4_rdptr", 32'(u_b.r_rd_ptr), 0);
        mr_b = 1;
        tick();
        chk("t4_drain", 32'(empty_b), 1);
        mr_b = 0;

        // T3 full with simultaneous push/pop, READY_COMB=1
        sv_b = 1; sd_b = 1;
        tick();
        sd_b = 2;
        tick();
        sd_b = 3;
        tick();
        sd_b = 4; mr_b = 1;
        #1;
        chk("t3b_full", 32'(full_b), 1);
        chk("t3b_sr",   32'(sr_b), 1);
        chk("t3b_head", md_b, 1);
        tick();
        sv_b = 0;
        #1;
        chk("t3b_cnt", 32'(cnt_b), 3);
        chk("t3b_pop2", md_b, 2);
        tick();
        chk("t3b_pop3", md_b, 3);
        tick();
        chk("t3b_pop4", md_b, 4);
        tick();
        chk("t3b_empty", 32'(empty_b), 1);
        mr_b = 0;

        // T3 same scenario, READY_COMB=0: beat 4 held upstream
        sv_c = 1; sd_c = 1;
        tick();
        sd_c = 2;
        tick();
        sd_c = 3;
        tick();
        sd_c = 4; mr_c = 1;
        #1;
        chk("t3c_sr_full", 32'(sr_c), 0);
        chk("t3c_head", md_c, 1);
        tick();
        chk("t3c_cnt", 32'(cnt_c), 2);
        chk("t3c_pop2", md_c, 2);
        chk("t3c_sr", 32'(sr_c), 1);
        tick();
        sv_c = 0;
        #1;
        chk("t3c_pop3", md_c, 3);
        tick();
        chk("t3c_pop4", md_c, 4);
        chk("t3c_cnt1", 32'(cnt_c), 1);
        tick();
        chk("t3c_empty", 32'(empty_c), 1);
        mr_c = 0;

        // T5 pointer wrap on DEPTH=3 from a fresh reset
        rst = 1;
        tick();
        rst = 0;
        for (int k = 0; k < 7; k++) begin
            sv_c = 1; sd_c = 32'(32'h70 + k); mr_c = 0;
            #1;
            chk("t5_wrptr", 32'(u_c.r_wr_ptr), 32'(k % 3));
            tick();
            sv_c = 0; mr_c = 1;
            #1;
            chk("t5_data",  md_c, 32'(32'h70 + k));
            chk("t5_rdptr", 32'(u_c.r_rd_ptr), 32'(k % 3));
            chk("t5_full",  32'(full_c), 0);
            tick();
        end
        mr_c = 0;

        // T6 perf counters on instance B
        rst = 1;
        tick();
        rst = 0;
        sv_b = 1; sd_b = 1; mr_b = 0;
        tick();
        sd_b = 2;
        tick();
        sd_b = 3;
        tick();
        sv_b = 0;
        tick(); tick(); tick();
        mr_b = 1;
        tick(); tick(); tick();
        tick(); tick();
        mr_b = 0;
        #1;
        chk("t6_stall",  ps_b, 32'(PE * 5));
        chk("t6_xfer",   px_b, 32'(PE * 3));
        chk("t6_bubble", pb_b, 32'(PE * 2));
        fl_b = 1;
        tick();
        fl_b = 0;
        chk("t6_fl_stall",  ps_b, 32'(PE * 5));
        chk("t6_fl_xfer",   px_b, 32'(PE * 3));
        chk("t6_fl_bubble", pb_b, 32'(PE * 2));
        rst = 1;
        tick();
        rst = 0;
        chk("t6_rst_stall",  ps_b, 0);
        chk("t6_rst_xfer",   px_b, 0);
        chk("t6_rst_bubble", pb_b, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
